// File: rtl/regfile_ctx_stack.sv
// Dual-read/dual-write register file with IO-mapped registers and a LIFO stack
// of saved context frames, moved one word per cycle by a small FSM.
module regfile_ctx_stack #(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 64,
  parameter int ADDR_W      = 6,
  parameter int CTX_REGS    = 16,
  parameter int STACK_DEPTH = 4,
  parameter int IO_IN_REG   = 15,
  parameter int IO_OUT_REG  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              re1,
  input  logic              re2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd1,
  input  logic [DATA_W-1:0] wd2,
  input  logic              we1,
  input  logic              we2,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);

  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int CW     = (CTX_REGS > 1) ? $clog2(CTX_REGS) : 1;
  localparam int FWORDS = STACK_DEPTH * CTX_REGS;
  localparam int FA_W   = (FWORDS > 1) ? $clog2(FWORDS) : 1;

  localparam logic [SP_W-1:0] SP_MAX   = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CTX_REGS - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t                         state, state_nxt;
  logic [CW-1:0]                  cnt, cnt_nxt;
  logic [SP_W-1:0]                sp, sp_nxt;
  logic                           done_nxt, err_nxt;

  logic [NREGS-1:0][DATA_W-1:0]   regs;
  logic [DATA_W-1:0]              frames [FWORDS];

  logic [DATA_W-1:0]              rdata1, rdata2, ctx_word, frame_rd;
  logic [SP_W-1:0]                fsel;
  logic [FA_W-1:0]                faddr;
  logic                           idle;

  assign idle        = (state == IDLE);
  assign busy        = !idle;
  assign stack_full  = (sp == SP_MAX);
  assign stack_empty = (sp == '0);

  // Restore pops the frame below sp; save pushes into the frame at sp.
  assign fsel     = (state == RESTORE) ? (sp - SP_ONE) : sp;
  assign faddr    = FA_W'(32'(fsel) * CTX_REGS + 32'(cnt));
  assign frame_rd = frames[faddr];

  // ---------------------------------------------------------------- read muxes
  always_comb begin
    rdata1   = '0;
    rdata2   = '0;
    ctx_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ra1 == ADDR_W'(i)) rdata1 = regs[i];
      if (ra2 == ADDR_W'(i)) rdata2 = regs[i];
    end
    for (int i = 0; i < CTX_REGS; i++)
      if (cnt == CW'(i)) ctx_word = regs[i];
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sp_nxt    = sp;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // save wins over a simultaneous restore; the restore is dropped silently
        if (save_req) begin
          if (sp != SP_MAX) state_nxt = SAVE;
          else              err_nxt   = 1'b1;
        end else if (restore_req) begin
          if (sp != '0) state_nxt = RESTORE;
          else          err_nxt   = 1'b1;
        end
      end
      SAVE, RESTORE: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          sp_nxt    = (state == SAVE) ? (sp + SP_ONE) : (sp - SP_ONE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sp    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sp    <= sp_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // ------------------------------------------------------------ register file
  // Port writes and io_in sampling only happen in IDLE; wd2 beats wd1 on a
  // shared address, and io_in beats both on the input-mapped register.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (idle) begin
          if (i == IO_IN_REG)                  regs[i] <= io_in;
          else if (we2 && wa2 == ADDR_W'(i))   regs[i] <= wd2;
          else if (we1 && wa1 == ADDR_W'(i))   regs[i] <= wd1;
        end else if (state == RESTORE && i < CTX_REGS && cnt == CW'(i)) begin
          regs[i] <= frame_rd;
        end
      end
    end
  end

  // Frame storage is deliberately not reset; sp=0 makes stale frames unreachable.
  always_ff @(posedge clk) begin
    if (!reset && state == SAVE) frames[faddr] <= ctx_word;
  end

  // ------------------------------------------------------- registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1    <= '0;
      rd2    <= '0;
      io_out <= '0;
    end else begin
      if (re1 && idle) rd1 <= rdata1;
      if (re2 && idle) rd2 <= rdata2;
      io_out <= regs[IO_OUT_REG];
    end
  end

endmodule

// File: tb/tb_regfile_ctx_stack.sv
// Scoreboard bench: stimulus pushes expected read data / done / err results into
// queues, a monitor pops and compares when the DUT presents them.
module tb_regfile_ctx_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ra1 = '0, ra2 = '0, wa1 = '0, wa2 = '0;
  logic        re1 = 1'b0, re2 = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic [15:0] wd1 = '0, wd2 = '0, io_in = 16'h00A5;
  logic        save_req = 1'b0, restore_req = 1'b0;
  logic [15:0] rd1, rd2, io_out;
  logic        busy, done, stack_full, stack_empty, err;

  regfile_ctx_stack dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .re1(re1), .re2(re2), .rd1(rd1), .rd2(rd2),
    .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2), .we1(we1), .we2(we2),
    .io_in(io_in), .io_out(io_out),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .stack_full(stack_full), .stack_empty(stack_empty),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q1[$], q2[$], qd[$], qe[$];
  int   total = 0, passed = 0;
  logic pend1 = 1'b0, pend2 = 1'b0;
  int   bcnt = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  function automatic logic [31:0] dexp(input logic full, input logic empty);
    return {8'd16, 22'd0, full, empty};
  endfunction

  // track which outputs are due and how long busy lasted
  always @(posedge clk) begin
    pend1 <= re1 && !busy && !reset;
    pend2 <= re2 && !busy && !reset;
    if (reset || done) bcnt <= 0;
    else if (busy)     bcnt <= bcnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend1) begin
      if (q1.size() == 0) chk("rd1_unexpected", 32'(rd1), 32'hFFFF_FFFF);
      else begin e = q1.pop_front(); chk(e.name, 32'(rd1), e.exp); end
    end
    if (pend2) begin
      if (q2.size() == 0) chk("rd2_unexpected", 32'(rd2), 32'hFFFF_FFFF);
      else begin e = q2.pop_front(); chk(e.name, 32'(rd2), e.exp); end
    end
    if (done) begin
      if (qd.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        e = qd.pop_front();
        chk(e.name, {8'(bcnt), 22'd0, stack_full, stack_empty}, e.exp);
      end
    end
    if (err) begin
      if (qe.size() == 0) chk("err_unexpected", 32'(err), 32'd0);
      else begin e = qe.pop_front(); chk(e.name, {30'd0, stack_full, stack_empty}, e.exp); end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input int port, input logic [5:0] a, input logic [15:0] v, input string n);
    exp_t e;
    e.name = n; e.exp = 32'(v);
    if (port == 1) begin re1 = 1'b1; ra1 = a; q1.push_back(e); end
    else           begin re2 = 1'b1; ra2 = a; q2.push_back(e); end
  endtask

  task automatic xfer(input logic s, input logic r, input string n, input logic [31:0] exp);
    exp_t e;
    e.name = n; e.exp = exp;
    save_req = s; restore_req = r;
    qd.push_back(e);
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    repeat (16) tick();
  endtask

  task automatic idle_in();
    re1 = 0; re2 = 0; we1 = 0; we2 = 0;
  endtask

  initial begin
    exp_t e;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_rd1", 32'(rd1), 0);
    chk("rst_rd2", 32'(rd2), 0);
    chk("rst_io_out", 32'(io_out), 0);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    chk("rst_flags", {stack_full, stack_empty}, 32'b01);

    // write then read; same-cycle read returns the pre-write value
    we1 = 1; wa1 = 3; wd1 = 16'hBEEF; rd(1, 3, 16'h0000, "rd_before_write");
    tick(); idle_in();
    rd(2, 3, 16'hBEEF, "rd_after_write");
    tick(); idle_in();

    // write conflict, io_in override, io_out lag
    we1 = 1; wa1 = 5; wd1 = 16'h1111; we2 = 1; wa2 = 5; wd2 = 16'h2222;
    tick(); idle_in();
    we1 = 1; wa1 = 15; wd1 = 16'hDEAD; we2 = 1; wa2 = 20; wd2 = 16'h1234;
    tick(); idle_in();
    rd(1, 5, 16'h2222, "wr_conflict");
    rd(2, 15, 16'h00A5, "io_in_override");
    tick(); idle_in();
    we1 = 1; wa1 = 16; wd1 = 16'h7777;
    tick(); idle_in();
    chk("io_out_lag", 32'(io_out), 0);
    tick();
    chk("io_out", 32'(io_out), 32'h7777);

    // save regs 0..15 = 1..16, clobber, restore
    io_in = 16'h0010;
    for (int k = 0; k < 16; k += 2) begin
      we1 = 1; wa1 = 6'(k);     wd1 = 16'(k + 1);
      we2 = 1; wa2 = 6'(k + 1); wd2 = 16'(k + 2);
      tick();
    end
    idle_in();
    xfer(1, 0, "done_save1", dexp(0, 0));
    io_in = 16'h0000;
    for (int k = 0; k < 16; k += 2) begin
      we1 = 1; wa1 = 6'(k);     wd1 = 16'h0;
      we2 = 1; wa2 = 6'(k + 1); wd2 = 16'h0;
      tick();
    end
    idle_in();
    xfer(0, 1, "done_restore1", dexp(0, 1));
    chk("empty_after_restore", 32'(stack_empty), 1);
    rd(1, 15, 16'h0010, "restore_r15");
    rd(2, 0, 16'h0001, "restore_r0");
    tick(); idle_in();
    for (int k = 1; k < 15; k += 2) begin
      rd(1, 6'(k),     16'(k + 1), "restore_rk");
      rd(2, 6'(k + 1), 16'(k + 2), "restore_rk");
      tick();
    end
    idle_in();

    // save+restore together saves; writes/reads during busy are ignored
    io_in = 16'h00A5;
    xfer(1, 0, "done_save_sp1", dexp(0, 0));
    e.name = "done_both_req"; e.exp = dexp(0, 0); qd.push_back(e);
    save_req = 1; restore_req = 1;
    tick();
    save_req = 0; restore_req = 0;
    we1 = 1; wa1 = 20; wd1 = 16'hABCD; re2 = 1; ra2 = 5;
    tick(); idle_in();
    chk("rd_hold_busy", 32'(rd2), 32'h000F);
    repeat (15) tick();
    rd(1, 20, 16'h1234, "wr_ignored_busy");
    tick(); idle_in();

    // fill the stack, overflow, drain, underflow
    xfer(1, 0, "done_save_sp3", dexp(0, 0));
    xfer(1, 0, "done_save_sp4", dexp(1, 0));
    chk("stack_full", 32'(stack_full), 1);
    e.name = "err_overflow"; e.exp = 32'b10; qe.push_back(e);
    save_req = 1; tick(); save_req = 0;
    chk("no_busy_overflow", {busy, stack_full}, 32'b01);
    xfer(0, 1, "done_pop3", dexp(0, 0));
    xfer(0, 1, "done_pop2", dexp(0, 0));
    xfer(0, 1, "done_pop1", dexp(0, 0));
    xfer(0, 1, "done_pop0", dexp(0, 1));
    e.name = "err_underflow"; e.exp = 32'b01; qe.push_back(e);
    restore_req = 1; tick(); restore_req = 0;
    chk("no_busy_underflow", {busy, stack_empty}, 32'b01);
    tick();

    // reset in the middle of a save aborts it
    save_req = 1; tick(); save_req = 0;
    repeat (7) tick();
    reset = 1; tick(); reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_empty", {stack_full, stack_empty}, 32'b01);
    chk("abort_rd", {rd1, rd2}, 0);
    repeat (20) tick();
    rd(1, 20, 16'h0000, "abort_r20");
    rd(2, 16, 16'h0000, "abort_r16");
    tick();
    rd(1, 5, 16'h0000, "abort_r5");
    rd(2, 3, 16'h0000, "abort_r3");
    tick(); idle_in();
    repeat (2) tick();

    foreach (q1[i]) chk({"missing_", q1[i].name}, 32'd0, 32'd1);
    foreach (q2[i]) chk({"missing_", q2[i].name}, 32'd0, 32'd1);
    foreach (qd[i]) chk({"missing_", qd[i].name}, 32'd0, 32'd1);
    foreach (qe[i]) chk({"missing_", qe[i].name}, 32'd0, 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_ctx_stack.md
REGFILE_CTX_STACK -- requirements
Module: regfile_ctx_stack

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- DATA_W, 16, register width.
- NREGS, 64, number of registers.
- ADDR_W, 6, address width; NREGS <= 2**ADDR_W.
- CTX_REGS, 16, registers 0..CTX_REGS-1 form the saved context.
- STACK_DEPTH, 4, number of context frames held.
- IO_IN_REG, 15, index of the input-mapped register.
- IO_OUT_REG, 16, index of the output-mapped register.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ra1, ra2  in  ADDR_W  read addresses.
- re1, re2  in  1  read enables.
- rd1, rd2  out  DATA_W  registered read data.
- wa1, wa2  in  ADDR_W  write addresses.
- wd1, wd2  in  DATA_W  write data.
- we1, we2  in  1  write enables.
- io_in  in  DATA_W  value sampled into register IO_IN_REG.
- io_out  out  DATA_W  registered copy of register IO_OUT_REG.
- save_req, restore_req  in  1  single-cycle context push / pop requests.
- busy  out  1  context transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- stack_full, stack_empty  out  1  stack pointer status.
- err  out  1  one-cycle pulse on a rejected request.

Function
REQ-003 Reads SHALL have 1-cycle latency: if reN=1 at edge t, rdN shows reg[raN] after t; if reN=0, rdN holds its value.
REQ-004 Reads SHALL return the pre-write value when the same register is written in the same cycle (read-before-write).
REQ-005 If we1 and we2 both target the same address in one cycle, wd2 SHALL be stored.
REQ-006 When not busy, reg[IO_IN_REG] SHALL load io_in every cycle, overriding any port write to that index.
REQ-007 io_out SHALL equal reg[IO_OUT_REG] as it stood before the current edge (one-cycle lag).
REQ-008 The FSM SHALL have exactly three states: IDLE, SAVE, RESTORE.
REQ-009 The context stack SHALL be STACK_DEPTH frames of CTX_REGS words, addressed by a stack pointer sp in the range 0..STACK_DEPTH.
REQ-010 In IDLE, save_req with sp<STACK_DEPTH SHALL enter SAVE, which copies reg[k] to frame[sp][k] for k=0..CTX_REGS-1, one word per cycle in ascending order; sp SHALL increment on the final copy.
REQ-011 In IDLE, restore_req with sp>0 (and save_req=0) SHALL enter RESTORE, which copies frame[sp-1][k] to reg[k], one word per cycle in ascending order; sp SHALL decrement on the final copy.
REQ-012 A request accepted at edge t SHALL give busy=1 for edges t+1..t+CTX_REGS, transferring word k at edge t+1+k; at edge t+CTX_REGS+1 the FSM SHALL be in IDLE with busy=0 and done=1 for that one cycle.
REQ-013 While busy: we1/we2, re1/re2, io_in sampling and new save/restore requests SHALL be ignored without err; rd1/rd2 SHALL hold their values.
REQ-014 save_req and restore_req asserted together in IDLE SHALL perform the save only; the restore SHALL be dropped with no err.
REQ-015 save_req when sp=STACK_DEPTH, or restore_req alone when sp=0, SHALL pulse err for one cycle and change no state.
REQ-016 stack_full SHALL equal (sp==STACK_DEPTH) and stack_empty SHALL equal (sp==0), both combinational from sp.
REQ-017 Registers at index >= CTX_REGS SHALL never be changed by SAVE or RESTORE.

Reset
REQ-018 On reset at an edge, the block SHALL set: all registers=0, rd1=rd2=0, io_out=0, sp=0, FSM=IDLE, busy=0, done=0, err=0.
REQ-019 Frame storage SHALL NOT be cleared by reset; with sp=0 its contents are unreachable.
REQ-020 Reset asserted during SAVE or RESTORE SHALL abort the transfer with no done pulse and leave sp=0.
REQ-021 Reset SHALL take priority over every other input.

Verification
REQ-022 Port write/read: we1 with wa1=3, wd1=0xBEEF; next cycle re2 with ra2=3 -> rd2=0xBEEF one cycle later; a same-cycle read of reg 3 returns the old value 0.
REQ-023 Write conflict and IO: we1 and we2 to reg 5 with 0x1111 and 0x2222 -> reg5=0x2222; io_in=0x00A5 -> reg15=0x00A5; write 0x7777 to reg 16 -> io_out=0x7777 on the following cycle.
REQ-024 Save then restore: set reg k=k+1 for k=0..15, pulse save_req -> busy for 16 cycles, done, sp=1; overwrite regs 0..15 with 0; pulse restore_req -> regs 0..15 = 1..16, sp=0, stack_empty=1.
REQ-025 Overflow and underflow: after 4 saves, stack_full=1 and a 5th save_req gives err=1 with sp=4; after 4 restores, a further restore_req gives err=1 with sp=0.
REQ-026 Reset at transfer cycle 8 of a SAVE -> next cycle busy=0, done never pulses, sp=0, all registers=0.
REQ-027 Concurrency: save_req and restore_req together with sp=1 -> SAVE runs and sp=2; we1 during busy leaves the target register unchanged.
